// File: rtl/scan_pkg.sv
// Definitions shared by the memory scanner and its UART packer:
// packer state encoding and default widths and framing constants.
package scan_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    HI,
    LO,
    CSUM
  } state_t;

  localparam int         DEF_ADDR_W    = 14;
  localparam int         DEF_DATA_W    = 16;
  localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/scan_fifo.sv
// Synchronous FIFO with a synchronous flush. The head entry is visible
// combinationally on rdata, and an occupancy count is exported.
module scan_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/scan_uart_packer.sv
// Captures scanner read data into a FIFO and serialises each scan as
// SYNC, big-endian samples, XOR checksum on a valid/ready byte port.
module scan_uart_packer
  import scan_pkg::*;
#(
  parameter int         DATA_W     = DEF_DATA_W,
  parameter int         ADDR_W     = DEF_ADDR_W,
  parameter int         FIFO_DEPTH = 8,
  parameter logic [7:0] SYNC_BYTE  = DEF_SYNC_BYTE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scan_start,
  input  logic [ADDR_W-1:0] read_select,
  input  logic              rd_valid,
  input  logic [DATA_W-1:0] rd_data,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              scan_hold,
  output logic              overflow,
  output logic              frame_done
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_t             state;
  logic [7:0]         csum;
  logic               last_seen;
  logic [DATA_W:0]    head;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  logic               xfer;
  logic               rd_last;
  logic               capture;
  logic               push;
  logic               pop;
  logic               drop;

  assign xfer    = tx_valid & tx_ready;
  assign rd_last = (read_select == {ADDR_W{1'b1}});
  assign pop     = (state == LO) && xfer && !scan_start;

  // A restart discards any read in the same cycle; after the last
  // address has been captured, further reads belong to no frame.
  assign capture = (state != IDLE) && !scan_start && rd_valid && !last_seen;
  assign push    = capture && (!fifo_full || pop);
  assign drop    = capture && fifo_full && !pop;

  assign scan_hold = (fifo_count == CNT_W'(FIFO_DEPTH));

  scan_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (scan_start),
    .push  (push),
    .pop   (pop),
    .wdata ({rd_last, rd_data}),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      tx_valid   <= 1'b0;
      tx_data    <= 8'h00;
      csum       <= 8'h00;
      overflow   <= 1'b0;
      last_seen  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (push && rd_last) last_seen <= 1'b1;
      if (drop)            overflow  <= 1'b1;

      if (scan_start) begin
        state     <= HDR;
        tx_valid  <= 1'b1;
        tx_data   <= SYNC_BYTE;
        csum      <= 8'h00;
        overflow  <= 1'b0;
        last_seen <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            tx_valid <= 1'b0;
          end
          HDR: begin
            if (xfer) begin
              state    <= HI;
              tx_valid <= 1'b0;
            end
          end
          HI: begin
            if (!tx_valid) begin
              if (!fifo_empty) begin
                tx_valid <= 1'b1;
                tx_data  <= head[DATA_W-1 -: 8];
              end
            end else if (tx_ready) begin
              // Head stays in place until its low byte goes out.
              csum    <= csum ^ tx_data;
              tx_data <= head[7:0];
              state   <= LO;
            end
          end
          LO: begin
            if (xfer) begin
              csum <= csum ^ tx_data;
              if (head[DATA_W]) begin
                state   <= CSUM;
                tx_data <= csum ^ tx_data;
              end else begin
                state    <= HI;
                tx_valid <= 1'b0;
              end
            end
          end
          CSUM: begin
            if (xfer) begin
              state      <= IDLE;
              tx_valid   <= 1'b0;
              frame_done <= 1'b1;
            end
          end
          default: begin
            state    <= IDLE;
            tx_valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_scan_uart_packer.sv
// Directed and randomized frames for scan_uart_packer, compared against a
// byte-level frame model built from the list of samples presented.
module tb_scan_uart_packer;
  import scan_pkg::*;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        scan_start = 1'b0;
  logic [13:0] read_select = '0;
  logic        rd_valid = 1'b0;
  logic [15:0] rd_data = '0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        scan_hold;
  logic        overflow;
  logic        frame_done;

  scan_uart_packer #(
    .DATA_W     (16),
    .ADDR_W     (14),
    .FIFO_DEPTH (DEPTH),
    .SYNC_BYTE  (8'hA5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .scan_start  (scan_start),
    .read_select (read_select),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .scan_hold   (scan_hold),
    .overflow    (overflow),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [13:0] addr;
    logic [15:0] data;
  } sample_t;

  int         checks = 0;
  int         errors = 0;
  sample_t    samples[$];
  logic [7:0] got[$];
  logic [7:0] expq[$];
  int         sidx = 0;
  int         xfers = 0;
  int         done_cnt = 0;
  int         cyc = 0;
  int         ready_mode = 0;
  bit         ignore_hold = 0;
  logic       stall_prev = 1'b0;
  logic [7:0] prev_data = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic add_sample(input logic [13:0] a, input logic [15:0] d);
    sample_t s;
    s.addr = a;
    s.data = d;
    samples.push_back(s);
  endtask

  // Frame model: sync byte, each sample high then low byte, XOR of payload.
  function automatic void build_expected(input int n);
    logic [7:0] x;
    x = 8'h00;
    expq = {};
    expq.push_back(8'hA5);
    for (int i = 0; i < n; i++) begin
      expq.push_back(samples[i].data[15:8]);
      expq.push_back(samples[i].data[7:0]);
      x = x ^ samples[i].data[15:8] ^ samples[i].data[7:0];
    end
    expq.push_back(x);
  endfunction

  task automatic compare_bytes(input string tag);
    check({tag, "_nbytes"}, got.size(), expq.size());
    for (int i = 0; i < expq.size() && i < got.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), got[i], expq[i]);
  endtask

  // One clock: set tx_ready, optionally present the next scanner read,
  // observe the port, then advance to 1 time unit after the next edge.
  task automatic step(input bit drive_scan);
    bit pop_now;
    bit hold_before;
    bit drove;
    cyc++;
    case (ready_mode)
      0:       tx_ready = 1'b1;
      1:       tx_ready = (cyc % 4 == 0);
      2:       tx_ready = 1'($urandom_range(0, 1));
      default: tx_ready = 1'b0;
    endcase
    // Transfers after the sync byte alternate high/low; a low-byte transfer pops.
    pop_now     = tx_valid && tx_ready && (xfers > 0) && (xfers % 2 == 0);
    hold_before = scan_hold;
    drove       = 0;
    if (drive_scan) begin
      if (sidx < samples.size() && (ignore_hold || !scan_hold || pop_now)) begin
        rd_valid    = 1'b1;
        read_select = samples[sidx].addr;
        rd_data     = samples[sidx].data;
        sidx++;
        drove = 1;
      end else begin
        rd_valid    = 1'b0;
        read_select = 14'($urandom);
        rd_data     = 16'($urandom);
      end
    end
    if (stall_prev) begin
      check("stall_valid", tx_valid, 1);
      check("stall_data", tx_data, prev_data);
    end
    if (tx_valid && tx_ready) begin
      got.push_back(tx_data);
      xfers++;
    end
    if (frame_done) done_cnt++;
    stall_prev = tx_valid && !tx_ready && !scan_start;
    prev_data  = tx_data;
    @(posedge clk);
    #1;
    if (drove && pop_now && hold_before && !ignore_hold)
      check("full_stream_hold", scan_hold, 1);
  endtask

  task automatic start_frame(input string tag);
    scan_start = 1'b1;
    rd_valid   = 1'b0;
    xfers      = 0;
    step(0);
    scan_start = 1'b0;
    xfers      = 0;
    got        = {};
    sidx       = 0;
    check({tag, "_start_valid"}, tx_valid, 1);
    check({tag, "_start_sync"}, tx_data, 8'hA5);
    check({tag, "_start_ovf"}, overflow, 0);
    check({tag, "_start_hold"}, scan_hold, 0);
  endtask

  task automatic run_frame(input string tag, input int budget);
    int d0;
    int n;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < budget) begin
      step(1);
      n++;
    end
    check({tag, "_done"}, done_cnt - d0, 1);
    step(1);
    step(1);
    check({tag, "_single_done"}, done_cnt - d0, 1);
    check({tag, "_idle_valid"}, tx_valid, 0);
    compare_bytes(tag);
  endtask

  initial begin
    int d0;
    int n;
    int k;

    // Reset values
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", tx_valid, 0);
    check("rst_data", tx_data, 8'h00);
    check("rst_hold", scan_hold, 0);
    check("rst_ovf", overflow, 0);
    check("rst_done", frame_done, 0);
    rst = 1'b1;
    step(0);

    // Basic two-sample frame, checksum 8'h40
    samples = {};
    add_sample(14'h3FFE, 16'h1234);
    add_sample(14'h3FFF, 16'hABCD);
    ready_mode = 0;
    start_frame("basic");
    build_expected(2);
    run_frame("basic", 200);

    // Same frame with tx_ready high one cycle in four
    ready_mode = 1;
    start_frame("bp");
    build_expected(2);
    run_frame("bp", 400);

    // Randomized frames with random back-pressure
    for (int r = 0; r < 4; r++) begin
      samples = {};
      k = $urandom_range(1, 12);
      for (int i = 0; i < k - 1; i++)
        add_sample(14'($urandom_range(0, 16382)), 16'($urandom));
      add_sample(14'h3FFF, 16'($urandom));
      ready_mode = 2;
      start_frame($sformatf("rnd%0d", r));
      build_expected(k);
      run_frame($sformatf("rnd%0d", r), 2000);
    end

    // Abort while the low byte is presented
    samples = {};
    add_sample(14'h0000, 16'h1111);
    add_sample(14'h0001, 16'h2222);
    ready_mode = 0;
    start_frame("abort_a");
    d0 = done_cnt;
    n  = 0;
    while (xfers < 2 && n < 100) begin
      step(1);
      n++;
    end
    check("abort_reach_lo", xfers, 2);
    check("abort_lo_valid", tx_valid, 1);
    check("abort_lo_data", tx_data, 8'h11);
    ready_mode  = 3;
    scan_start  = 1'b1;
    rd_valid    = 1'b1;
    read_select = 14'h3FFF;
    rd_data     = 16'hDEAD;
    step(0);
    scan_start = 1'b0;
    rd_valid   = 1'b0;
    check("abort_restart_valid", tx_valid, 1);
    check("abort_restart_sync", tx_data, 8'hA5);
    samples = {};
    add_sample(14'h3FFF, 16'h5A5A);
    sidx  = 0;
    xfers = 0;
    got   = {};
    ready_mode = 0;
    build_expected(1);
    run_frame("abort_b", 200);
    check("abort_total_done", done_cnt - d0, 1);

    // Full FIFO streaming: push while popping on a full FIFO
    samples = {};
    for (int i = 0; i < 11; i++) add_sample(14'(i), 16'($urandom));
    add_sample(14'h3FFF, 16'($urandom));
    ready_mode = 3;
    start_frame("stream");
    repeat (10) step(1);
    check("stream_fill_hold", scan_hold, 1);
    check("stream_fill_count", sidx, DEPTH);
    ready_mode = 0;
    build_expected(12);
    run_frame("stream", 400);
    check("stream_no_ovf", overflow, 0);

    // Overflow: ten reads into an eight-entry FIFO with the UART stalled
    samples = {};
    for (int i = 0; i < 10; i++) add_sample(14'(i), 16'($urandom));
    ready_mode = 3;
    start_frame("ovf");
    ignore_hold = 1;
    for (int i = 1; i <= 10; i++) begin
      step(1);
      check($sformatf("ovf_hold_%0d", i), scan_hold, (i >= 8));
      check($sformatf("ovf_flag_%0d", i), overflow, (i >= 9));
    end
    ignore_hold = 0;
    check("ovf_hdr_valid", tx_valid, 1);
    check("ovf_hdr_data", tx_data, 8'hA5);
    expq = {};
    expq.push_back(8'hA5);
    for (int i = 0; i < DEPTH; i++) begin
      expq.push_back(samples[i].data[15:8]);
      expq.push_back(samples[i].data[7:0]);
    end
    ready_mode = 0;
    d0 = done_cnt;
    repeat (80) step(1);
    compare_bytes("ovf");
    check("ovf_no_done", done_cnt - d0, 0);
    check("ovf_sticky", overflow, 1);
    check("ovf_drained_valid", tx_valid, 0);

    // Asynchronous reset mid-frame with the FIFO full and tx_valid high
    samples = {};
    for (int i = 0; i < 9; i++) add_sample(14'(i), 16'($urandom));
    ready_mode = 3;
    start_frame("arst");
    ignore_hold = 1;
    repeat (9) step(1);
    ignore_hold = 0;
    rd_valid = 1'b0;
    check("arst_pre_hold", scan_hold, 1);
    check("arst_pre_ovf", overflow, 1);
    check("arst_pre_valid", tx_valid, 1);
    #2;
    rst = 1'b0;
    #1;
    check("arst_valid", tx_valid, 0);
    check("arst_data", tx_data, 8'h00);
    check("arst_hold", scan_hold, 0);
    check("arst_ovf", overflow, 0);
    check("arst_done", frame_done, 0);
    @(posedge clk);
    #1;
    check("arst_held_valid", tx_valid, 0);
    check("arst_held_done", frame_done, 0);
    rst        = 1'b1;
    stall_prev = 1'b0;

    // Normal frame after reset
    samples = {};
    add_sample(14'h3FFE, 16'h1234);
    add_sample(14'h3FFF, 16'hABCD);
    ready_mode = 0;
    start_frame("post");
    build_expected(2);
    run_frame("post", 200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
